// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART byte path (TX side today, RX later).
//   tx_state_t : transmitter FSM state encoding
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of the stop bit (also the idle level)
//   DATA_BITS  : data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Byte-wide synchronous FIFO, 2**DEPTH_LOG2 entries, first-word-fall-through:
// the head byte is visible on pop_data whenever empty is low.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset (pointers only)
//   push, push_data  : write push_data at the tail on the edge (ignored if full)
//   pop              : advance the head on the edge (ignored if empty)
//   pop_data         : current head byte
//   full, empty      : occupancy flags, derived from the registered pointers
//   count            : number of stored bytes (0..2**DEPTH_LOG2)
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [7:0]          mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] head;
  logic [DEPTH_LOG2:0] tail;
  logic                do_push;
  logic                do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = tail - head;
  assign empty    = (tail == head);
  assign full     = (tail[DEPTH_LOG2-1:0] == head[DEPTH_LOG2-1:0]) &&
                    (tail[DEPTH_LOG2] != head[DEPTH_LOG2]);
  assign pop_data = mem[head[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit end of the UART byte path: buffers bytes from the core and
// serializes them onto txd as start / 8 data bits LSB first / [parity] / stop.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (11-bit frames instead of 10).
// Ports:
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset (drops buffered bytes, txd -> 1)
//   txdata   : byte from the core
//   txwrite  : push strobe for txdata
//   txfull   : buffer full; the core must hold its store while high
//   txbusy   : bytes buffered, frame in progress, or stop bit still on the line
//   txcount  : bytes buffered, not counting the frame on the wire
//   overflow : sticky, set when txwrite arrives while txfull is high
//   txd      : serial output, idle high, driven from a flop
// Handshake: txwrite is a single-cycle strobe with no ready return; the byte
// is taken on the edge when txwrite is high and the registered txfull is low,
// otherwise it is dropped and overflow latches.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            txdata,
  input  logic                  txwrite,
  output logic                  txfull,
  output logic                  txbusy,
  output logic [DEPTH_LOG2:0]   txcount,
  output logic                  overflow,
  output logic                  txd
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t   state;
  tx_state_t   next_state;

  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_cnt;
  logic        bit_advance;
  logic        state_entry;
  logic [7:0]  shift_q;
  logic        txd_next;
  logic        txd_q;
  logic        line_busy_q;
  logic        overflow_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (txwrite),
    .push_data (txdata),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (txcount)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!fifo_empty) next_state = START;
      START:  if (baud_done) next_state = DATA;
      DATA: begin
        if (baud_done && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
      PARITY: if (baud_done) next_state = STOP;
      // Chain straight into the next frame when a byte is already waiting.
      STOP:   if (baud_done) next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    pop         = 1'b0;
    bit_advance = 1'b0;
    txd_next    = STOP_BIT;
    case (state)
      IDLE: begin
        pop      = !fifo_empty;
        txd_next = STOP_BIT;
      end
      START: txd_next = START_BIT;
      DATA: begin
        txd_next    = shift_q[0];
        bit_advance = baud_done;
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        txd_next = parity_q;
`else
        txd_next = STOP_BIT;
`endif
      end
      STOP: begin
        pop      = baud_done && !fifo_empty;
        txd_next = STOP_BIT;
      end
      default: txd_next = STOP_BIT;
    endcase
  end

  assign state_entry = (next_state != state);

  // ------------------------------------------------------------ datapath regs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      txd_q       <= STOP_BIT;
      line_busy_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (state == IDLE || state_entry || baud_done) baud_cnt <= '0;
      else                                           baud_cnt <= baud_cnt + 16'd1;

      if (state_entry)      bit_cnt <= '0;
      else if (bit_advance) bit_cnt <= bit_cnt + 3'd1;

      if (pop)              shift_q <= fifo_data;
      else if (bit_advance) shift_q <= {1'b0, shift_q[7:1]};

      // txd lags the state by one cycle; line_busy_q tracks that lag so
      // txbusy stays high until the stop bit has fully left the pin.
      txd_q       <= txd_next;
      line_busy_q <= (state != IDLE);

      if (txwrite && fifo_full) overflow_q <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    parity_q <= 1'b0;
    else if (pop) parity_q <= ^fifo_data;
  end
`endif

  assign txd      = txd_q;
  assign txfull   = fifo_full;
  assign overflow = overflow_q;
  assign txbusy   = (state != IDLE) || !fifo_empty || line_busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo with CLK_PER_BIT=4, DEPTH_LOG2=2. Cycle n is the
// interval after rising edge n of a scenario; a write "at cycle k" is high
// before edge k. The reference model works on whole frames: each accepted byte
// gets a start time max(k+2, previous start + frame length) and the expected
// line level, occupancy, busy, full and overflow per cycle follow from that.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int F     = NB * C;
  localparam int MAXC  = 700;

  logic          clk;
  logic          rstn;
  logic [7:0]    txdata;
  logic          txwrite;
  logic          txfull;
  logic          txbusy;
  logic [DL:0]   txcount;
  logic          overflow;
  logic          txd;

  uart_tx_fifo #(
    .CLK_PER_BIT (C),
    .DEPTH_LOG2  (DL)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .txdata   (txdata),
    .txwrite  (txwrite),
    .txfull   (txfull),
    .txbusy   (txbusy),
    .txcount  (txcount),
    .overflow (overflow),
    .txd      (txd)
  );

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ----------------------------------------------------------- stimulus plan
  logic       wr_en  [MAXC];
  logic [7:0] wr_dat [MAXC];

  // ------------------------------------------------------- reference model
  logic [7:0] exp_q[$];     // accepted bytes in transmit order
  int         fr_start[$];  // cycle at which each frame's start bit appears
  int         acc_cyc[$];   // cycle at which each byte was accepted
  int         rej_first;    // first cycle a write was dropped

  logic       e_txd;
  logic [DL:0] e_cnt;
  logic       e_busy;
  logic       e_full;
  logic       e_ovf;

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      wr_en[i]  = 1'b0;
      wr_dat[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic build_model(input int n_cyc);
    int prev;
    int cnt;
    int s;
    exp_q.delete();
    fr_start.delete();
    acc_cyc.delete();
    rej_first = 1 << 30;
    prev = -100000;
    for (int k = 0; k < n_cyc; k++) begin
      if (wr_en[k]) begin
        // Bytes still waiting in the buffer as seen at edge k.
        cnt = 0;
        for (int j = 0; j < fr_start.size(); j++)
          if (fr_start[j] - 1 >= k) cnt++;
        if (cnt >= DEPTH) begin
          if (rej_first > k) rej_first = k;
        end else begin
          s = (k + 2 > prev + F) ? k + 2 : prev + F;
          exp_q.push_back(wr_dat[k]);
          fr_start.push_back(s);
          acc_cyc.push_back(k);
          prev = s;
        end
      end
    end
  endtask

  function automatic void model_at(input int n);
    int         cnt;
    int         b;
    logic       busy;
    logic [7:0] byt;
    cnt   = 0;
    busy  = 1'b0;
    e_txd = 1'b1;
    for (int j = 0; j < fr_start.size(); j++) begin
      if (acc_cyc[j] <= n && fr_start[j] - 1 > n) cnt++;
      if (fr_start[j] - 1 <= n && n <= fr_start[j] + F - 1) busy = 1'b1;
      if (fr_start[j] <= n && n < fr_start[j] + F) begin
        b   = (n - fr_start[j]) / C;
        byt = exp_q[j];
        if (b == 0)      e_txd = 1'b0;
        else if (b <= 8) e_txd = byt[b-1];
`ifdef UART_TX_PARITY_EN
        else if (b == 9) e_txd = ^byt;
`endif
        else             e_txd = 1'b1;
      end
    end
    e_cnt  = (DL+1)'(cnt);
    e_busy = busy || (cnt != 0);
    e_full = (cnt == DEPTH);
    e_ovf  = (n >= rej_first);
  endfunction

  // ----------------------------------------------------------------- driver
  task automatic do_reset();
    txwrite = 1'b0;
    rstn    = 1'b0;
    repeat (3) @(negedge clk);
    rstn    = 1'b1;
  endtask

  task automatic drive_cycle(input int n);
    txwrite = wr_en[n];
    txdata  = wr_dat[n];
    @(posedge clk);
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rstn    = 1'b0;
    txwrite = 1'b0;
    txdata  = 8'h00;
    #1;
    for (int i = 0; i < 8; i++) begin
      txwrite = 1'($urandom_range(0, 1));
      txdata  = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_tests++;
      if (txd !== 1'b1) begin n_fail++; $display("FAIL reset txd cyc %0d: got %b exp 1", i, txd); end
      n_tests++;
      if (txcount !== '0) begin n_fail++; $display("FAIL reset txcount cyc %0d: got %0d exp 0", i, txcount); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow cyc %0d: got %b exp 0", i, overflow); end
      n_tests++;
      if ({txbusy, txfull} !== 2'b00) begin n_fail++; $display("FAIL reset busy/full cyc %0d: got %b exp 00", i, {txbusy, txfull}); end
    end
    txwrite = 1'b0;
    rstn    = 1'b1;
  endtask

  task automatic test_single();
    clear_stim();
    wr_en[0] = 1'b1; wr_dat[0] = 8'hA5;
    build_model(60);
    do_reset();
    for (int n = 0; n < 60; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL single txd cyc %0d: got %b exp %b", n, txd, e_txd); end
      n_tests++;
      if (txbusy !== e_busy) begin n_fail++; $display("FAIL single txbusy cyc %0d: got %b exp %b", n, txbusy, e_busy); end
      n_tests++;
      if (txcount !== e_cnt) begin n_fail++; $display("FAIL single txcount cyc %0d: got %0d exp %0d", n, txcount, e_cnt); end
    end
    txwrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      wr_en[i]  = 1'b1;
      wr_dat[i] = 8'(i + 1);
    end
    build_model(140);
    do_reset();
    for (int n = 0; n < 140; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL burst txd cyc %0d: got %b exp %b", n, txd, e_txd); end
      n_tests++;
      if (txbusy !== e_busy) begin n_fail++; $display("FAIL burst txbusy cyc %0d: got %b exp %b", n, txbusy, e_busy); end
      n_tests++;
      if (txcount !== e_cnt) begin n_fail++; $display("FAIL burst txcount cyc %0d: got %0d exp %0d", n, txcount, e_cnt); end
    end
    txwrite = 1'b0;
  endtask

  task automatic test_overflow();
    clear_stim();
    for (int i = 0; i < 6; i++) begin
      wr_en[i]  = 1'b1;
      wr_dat[i] = 8'h10 + 8'(i);
    end
    build_model(220);
    do_reset();
    for (int n = 0; n < 220; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL ovf txd cyc %0d: got %b exp %b", n, txd, e_txd); end
      n_tests++;
      if (txcount !== e_cnt) begin n_fail++; $display("FAIL ovf txcount cyc %0d: got %0d exp %0d", n, txcount, e_cnt); end
      n_tests++;
      if (txfull !== e_full) begin n_fail++; $display("FAIL ovf txfull cyc %0d: got %b exp %b", n, txfull, e_full); end
      n_tests++;
      if (overflow !== e_ovf) begin n_fail++; $display("FAIL ovf overflow cyc %0d: got %b exp %b", n, overflow, e_ovf); end
    end
    txwrite = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    clear_stim();
    wr_en[0] = 1'b1; wr_dat[0] = 8'hA5;
    wr_en[1] = 1'b1; wr_dat[1] = 8'h3C;
    build_model(20);
    do_reset();
    // Cycle 19 sits inside data bit 3 of the first frame.
    for (int n = 0; n < 20; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL midrst txd cyc %0d: got %b exp %b", n, txd, e_txd); end
    end
    txwrite = 1'b0;
    rstn    = 1'b0;
    #1;
    n_tests++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst txd at reset: got %b exp 1", txd); end
    n_tests++;
    if (txcount !== '0) begin n_fail++; $display("FAIL midrst txcount at reset: got %0d exp 0", txcount); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      n_tests++;
      if ({txd, txbusy} !== 2'b10) begin n_fail++; $display("FAIL midrst idle after release cyc %0d: got txd/busy %b exp 10", n, {txd, txbusy}); end
    end
  endtask

  task automatic test_random(input int rate, input int seed_tag);
    clear_stim();
    for (int k = 0; k < 300; k++)
      wr_en[k] = ($urandom_range(0, rate - 1) == 0);
    build_model(500);
    do_reset();
    for (int n = 0; n < 500; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL rand%0d txd cyc %0d: got %b exp %b", seed_tag, n, txd, e_txd); end
      n_tests++;
      if (txcount !== e_cnt) begin n_fail++; $display("FAIL rand%0d txcount cyc %0d: got %0d exp %0d", seed_tag, n, txcount, e_cnt); end
      n_tests++;
      if (txbusy !== e_busy) begin n_fail++; $display("FAIL rand%0d txbusy cyc %0d: got %b exp %b", seed_tag, n, txbusy, e_busy); end
      n_tests++;
      if (txfull !== e_full) begin n_fail++; $display("FAIL rand%0d txfull cyc %0d: got %b exp %b", seed_tag, n, txfull, e_full); end
      n_tests++;
      if (overflow !== e_ovf) begin n_fail++; $display("FAIL rand%0d overflow cyc %0d: got %b exp %b", seed_tag, n, overflow, e_ovf); end
    end
    txwrite = 1'b0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    clear_stim();
    wr_en[0] = 1'b1; wr_dat[0] = 8'h07;
    wr_en[1] = 1'b1; wr_dat[1] = 8'h5A;
    build_model(100);
    do_reset();
    for (int n = 0; n < 100; n++) begin
      drive_cycle(n);
      model_at(n);
      n_tests++;
      if (txd !== e_txd) begin n_fail++; $display("FAIL parity txd cyc %0d: got %b exp %b", n, txd, e_txd); end
      n_tests++;
      if (txbusy !== e_busy) begin n_fail++; $display("FAIL parity txbusy cyc %0d: got %b exp %b", n, txbusy, e_busy); end
    end
    txwrite = 1'b0;
  endtask
`endif

  // ------------------------------------------------------------------ main
  initial begin
    txwrite = 1'b0;
    txdata  = 8'h00;
    rstn    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_random(10, 1);
    test_random(45, 2);
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
